ahb_slave_mem: RTL and testbench

//  AHB-Lite responder: word-organised memory slave answering the transfers that
//  the AHB masters generate (SINGLE/INCR/INCRx/WRAPx, BYTE/HALF_WORD/WORD).

---
 rtl/ahb_params_pkg.sv | 70 +++++++
 rtl/ahb_burst_addr_calc.sv | 55 +++++
 rtl/ahb_slave_mem.sv | 263 ++++++++++++++++++++++++++
 tb/tb_ahb_slave_mem.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_params_pkg.sv
// ---------------------------------------------------------------------------
// ahb_params_pkg
// Shared AHB-Lite encodings and helpers for the memory slave:
//   - HTRANS / HSIZE / HBURST encodings
//   - HRESP encoding (hresp_t)
//   - slave FSM states (slv_state_t)
//   - beats_of(): beat count of a fixed-length burst (0 = unbounded INCR)
//   - lane_mask(): little-endian byte-lane enables for a transfer
//   - is_wrap(): true for the WRAP burst types
// ---------------------------------------------------------------------------
package ahb_params_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    typedef enum logic {
        RESP_OKAY  = 1'b0,
        RESP_ERROR = 1'b1
    } hresp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } slv_state_t;

    // Undefined-length INCR returns 0 so callers can skip the overrun check.
    function automatic logic [4:0] beats_of(input logic [2:0] hburst);
        case (hburst)
            HBURST_SINGLE:               beats_of = 5'd1;
            HBURST_WRAP4,  HBURST_INCR4:  beats_of = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  beats_of = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: beats_of = 5'd16;
            default:                      beats_of = 5'd0;
        endcase
    endfunction

    function automatic logic is_wrap(input logic [2:0] hburst);
        is_wrap = (hburst == HBURST_WRAP4) || (hburst == HBURST_WRAP8) ||
                  (hburst == HBURST_WRAP16);
    endfunction

    // Sizes above WORD never reach the write path (they are errored), so
    // they simply fall into the full-word case here.
    function automatic logic [3:0] lane_mask(input logic [2:0] hsize,
                                             input logic [1:0] addr_lo);
        case (hsize)
            HSIZE_BYTE: lane_mask = 4'b0001 << addr_lo;
            HSIZE_HALF: lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:    lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_burst_addr_calc.sv
// ---------------------------------------------------------------------------
// ahb_burst_addr_calc
// Combinational next-beat address for an AHB burst.
//   addr      in  current beat byte address
//   hsize     in  transfer size (BYTE/HALF_WORD/WORD; larger treated as WORD)
//   hburst    in  burst type
//   next_addr out address the following SEQ beat must carry
// INCR types step by the transfer size; WRAP types step by the size and wrap
// inside a window of beats*size bytes aligned to that window.
// ---------------------------------------------------------------------------
module ahb_burst_addr_calc
    import ahb_params_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] size_bytes;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] wrap_mask;

    // Step size, linear increment and wrap window mask, then pick the result.
    always_comb begin
        size_bytes = ADDR_WIDTH'(4);
        wrap_mask  = '0;
        next_addr  = '0;

        case (hsize)
            HSIZE_BYTE: size_bytes = ADDR_WIDTH'(1);
            HSIZE_HALF: size_bytes = ADDR_WIDTH'(2);
            default:    size_bytes = ADDR_WIDTH'(4);
        endcase

        incr_addr = addr + size_bytes;

        case (hburst)
            HBURST_WRAP4:  wrap_mask = (size_bytes << 2) - ADDR_WIDTH'(1);
            HBURST_WRAP8:  wrap_mask = (size_bytes << 3) - ADDR_WIDTH'(1);
            HBURST_WRAP16: wrap_mask = (size_bytes << 4) - ADDR_WIDTH'(1);
            default:       wrap_mask = '0;
        endcase

        // Upper bits stay at the window base, lower bits roll over.
        if (is_wrap(hburst)) begin
            next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
        end else begin
            next_addr = incr_addr;
        end
    end

endmodule

// File: rtl/ahb_slave_mem.sv
// ---------------------------------------------------------------------------
// ahb_slave_mem
// AHB-Lite word-organised memory responder with programmable wait states and
// two-cycle ERROR responses.
//   HCLK, HRESETn      clock (rising edge) / asynchronous active-low reset
//   HSEL, HADDR,       address phase inputs; a transfer is taken when
//   HTRANS, HWRITE,      HSEL & HREADY & HTRANS[1]
//   HSIZE, HBURST
//   HWDATA             write data, used in the completing data-phase cycle
//   HREADY             bus-level ready (muxed HREADYOUT)
//   HREADYOUT, HRESP   this slave's ready / response (0 OKAY, 1 ERROR)
//   HRDATA             read data, valid while HREADYOUT=1, holds otherwise
//   burst_err_cnt      saturating count of burst-sequence errors
//                      (port exists only with AHB_SLV_BURST_CHECK_EN)
// Optional feature macro: AHB_SLV_BURST_CHECK_EN enables tracking of SEQ
// beats against the expected burst address / beat count. Without it SEQ is
// handled exactly like NONSEQ.
// ---------------------------------------------------------------------------
module ahb_slave_mem
    import ahb_params_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA
`ifdef AHB_SLV_BURST_CHECK_EN
    ,
    output logic [7:0]            burst_err_cnt
`endif
);

    localparam int                  IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_WORDS * 4);
    localparam logic [3:0]          WAIT_LOAD = 4'(WAIT_STATES);

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    slv_state_t        state_q, state_d;
    logic              dp_q, dp_d;
    logic [3:0]        wait_q, wait_d;
    logic [IDX_W-1:0]  word_idx_q, word_idx_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [2:0]        size_q, size_d;
    logic              write_q, write_d;
    logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;

    logic       hreadyout;
    logic       hresp;
    logic       accept;
    logic       complete;
    logic       mem_we;
    logic [3:0] wr_mask;
    logic       size_err, align_err, range_err, burst_err, xfer_err;

    // Ready/response are pure functions of the registered state so the
    // accept decision below never loops back through them.
    assign hreadyout = !((state_q == ST_ERR1) ||
                         ((state_q == ST_WAIT) && (wait_q != 4'd0)));
    assign hresp     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? RESP_ERROR
                                                                      : RESP_OKAY;
    assign HREADYOUT = hreadyout;
    assign HRESP     = hresp;

    assign accept = HSEL && HREADY && HTRANS[1] && hreadyout;

    assign size_err  = (HSIZE > HSIZE_WORD);
    assign align_err = ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                       ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));
    assign range_err = ({1'b0, HADDR} >= MEM_BYTES);
    assign xfer_err  = size_err || align_err || range_err || burst_err;

`ifdef AHB_SLV_BURST_CHECK_EN
    logic [ADDR_WIDTH-1:0] exp_addr_q, exp_addr_d;
    logic [ADDR_WIDTH-1:0] calc_next;
    logic [4:0]            beat_cnt_q, beat_cnt_d;
    logic [2:0]            burst_q, burst_d;
    logic [7:0]            err_cnt_q, err_cnt_d;
    logic                  is_seq;
    logic                  overrun;

    ahb_burst_addr_calc #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_burst_addr_calc (
        .addr      (HADDR),
        .hsize     (HSIZE),
        .hburst    (HBURST),
        .next_addr (calc_next)
    );

    assign is_seq    = (HTRANS == HTRANS_SEQ);
    // Only fixed-length bursts can overrun; beats_of()==0 marks plain INCR.
    assign overrun   = (beats_of(burst_q) != 5'd0) && (beat_cnt_q >= beats_of(burst_q));
    assign burst_err = is_seq && ((HADDR != exp_addr_q) || overrun);

    // Track the running burst on every accepted beat. The expected address
    // is re-derived from the presented address even on a mismatch so one
    // bad beat does not cascade into errors on every later beat.
    always_comb begin
        exp_addr_d = exp_addr_q;
        beat_cnt_d = beat_cnt_q;
        burst_d    = burst_q;
        err_cnt_d  = err_cnt_q;
        if (accept) begin
            exp_addr_d = calc_next;
            if (is_seq) begin
                if (beat_cnt_q != 5'h1F) begin
                    beat_cnt_d = beat_cnt_q + 5'd1;
                end
            end else begin
                burst_d    = HBURST;
                beat_cnt_d = 5'd1;
            end
            if (burst_err && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    // Burst-tracking registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            exp_addr_q <= '0;
            beat_cnt_q <= 5'd0;
            burst_q    <= HBURST_SINGLE;
            err_cnt_q  <= 8'd0;
        end else begin
            exp_addr_q <= exp_addr_d;
            beat_cnt_q <= beat_cnt_d;
            burst_q    <= burst_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign burst_err_cnt = err_cnt_q;
`else
    logic unused_burst_inputs;

    assign burst_err           = 1'b0;
    assign unused_burst_inputs = ^{HBURST, HTRANS[0]};
`endif

    // FSM next state and data-phase bookkeeping. A new address phase is
    // considered only in cycles where this slave drives HREADYOUT high,
    // i.e. where any pending data phase is finishing.
    always_comb begin
        state_d    = state_q;
        dp_d       = dp_q;
        wait_d     = wait_q;
        word_idx_d = word_idx_q;
        addr_lo_d  = addr_lo_q;
        size_d     = size_q;
        write_d    = write_q;
        complete   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                complete = dp_q;
            end
            ST_WAIT: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else begin
                    complete = 1'b1;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            ST_ERR2: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (hreadyout) begin
            state_d = ST_IDLE;
            dp_d    = 1'b0;
            if (accept) begin
                word_idx_d = HADDR[IDX_W+1:2];
                addr_lo_d  = HADDR[1:0];
                size_d     = HSIZE;
                write_d    = HWRITE;
                if (xfer_err) begin
                    state_d = ST_ERR1;
                end else begin
                    dp_d = 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        wait_d  = WAIT_LOAD;
                    end
                end
            end
        end
    end

    // Read data mux. Memory is read asynchronously in the completing cycle,
    // so a read right after a write to the same word already sees the
    // written value (the write lands on the edge between the two phases).
    always_comb begin
        hrdata_d = hrdata_q;
        if ((state_q == ST_ERR1) || (state_q == ST_ERR2)) begin
            hrdata_d = '0;
        end else if (complete && !write_q) begin
            hrdata_d = mem[word_idx_q];
        end
    end

    assign HRDATA  = hrdata_d;
    assign mem_we  = complete && write_q;
    assign wr_mask = lane_mask(size_q, addr_lo_q);

    // Control registers. Reset clears the pending data phase, which drops
    // any write that has not yet reached its completing edge.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= ST_IDLE;
            dp_q       <= 1'b0;
            wait_q     <= 4'd0;
            word_idx_q <= '0;
            addr_lo_q  <= 2'b00;
            size_q     <= HSIZE_BYTE;
            write_q    <= 1'b0;
            hrdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            dp_q       <= dp_d;
            wait_q     <= wait_d;
            word_idx_q <= word_idx_d;
            addr_lo_q  <= addr_lo_d;
            size_q     <= size_d;
            write_q    <= write_d;
            hrdata_q   <= hrdata_d;
        end
    end

    // Memory array: no reset, byte-lane write enables.
    always_ff @(posedge HCLK) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) begin
                    mem[word_idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// ---------------------------------------------------------------------------
// tb_ahb_slave_mem
// Two slave instances share one bus: dut0 (no wait states) and dut2
// (two wait states), both with a 64-word memory. A pipelined master engine
// walks a table of transfers with hand-computed expected results; the reset
// in the middle of a wait-state write is a hand-written sequence.
// ---------------------------------------------------------------------------
module tb_ahb_slave_mem;
    import ahb_params_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        hsel0, hsel2, tgt;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY;

    logic        rdy0, rdy2, resp0, resp2;
    logic [31:0] rdata0, rdata2;
    logic        bus_resp;
    logic [31:0] bus_rdata;
`ifdef AHB_SLV_BURST_CHECK_EN
    logic [7:0]  bec0, bec2;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [1:0]  trans;
        logic [2:0]  burst;
        logic [31:0] wdata;
        logic        chk_data;
        logic [31:0] exp_data;
        logic        exp_resp;
        int          exp_low;
    } vec_t;

    vec_t vecs[64];
    int   n_vec = 0;

    always #5 HCLK = ~HCLK;

    assign HREADY    = tgt ? rdy2   : rdy0;
    assign bus_resp  = tgt ? resp2  : resp0;
    assign bus_rdata = tgt ? rdata2 : rdata0;

    ahb_slave_mem #(
        .ADDR_WIDTH (32), .DATA_WIDTH (32), .MEM_WORDS (64), .WAIT_STATES (0)
    ) dut0 (
        .HCLK (HCLK), .HRESETn (HRESETn), .HSEL (hsel0), .HADDR (HADDR),
        .HTRANS (HTRANS), .HWRITE (HWRITE), .HSIZE (HSIZE), .HBURST (HBURST),
        .HWDATA (HWDATA), .HREADY (HREADY), .HREADYOUT (rdy0), .HRESP (resp0),
        .HRDATA (rdata0)
`ifdef AHB_SLV_BURST_CHECK_EN
        , .burst_err_cnt (bec0)
`endif
    );

    ahb_slave_mem #(
        .ADDR_WIDTH (32), .DATA_WIDTH (32), .MEM_WORDS (64), .WAIT_STATES (2)
    ) dut2 (
        .HCLK (HCLK), .HRESETn (HRESETn), .HSEL (hsel2), .HADDR (HADDR),
        .HTRANS (HTRANS), .HWRITE (HWRITE), .HSIZE (HSIZE), .HBURST (HBURST),
        .HWDATA (HWDATA), .HREADY (HREADY), .HREADYOUT (rdy2), .HRESP (resp2),
        .HRDATA (rdata2)
`ifdef AHB_SLV_BURST_CHECK_EN
        , .burst_err_cnt (bec2)
`endif
    );

    // One comparison: counts it, reports a failure with actual/required.
    task automatic checkValue(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic wr, input logic [31:0] addr,
                          input logic [2:0] size, input logic [1:0] trans,
                          input logic [2:0] burst, input logic [31:0] wdata,
                          input logic chk_data, input logic [31:0] exp_data,
                          input logic exp_resp, input int exp_low);
        vecs[n_vec] = '{wr, addr, size, trans, burst, wdata,
                        chk_data, exp_data, exp_resp, exp_low};
        n_vec++;
    endtask

    // Drives the address phase of vector idx, or IDLE when idx < 0.
    task automatic applyStimulus(input int idx);
        if (idx < 0) begin
            HTRANS = HTRANS_IDLE;
        end else begin
            HADDR  = vecs[idx].addr;
            HWRITE = vecs[idx].wr;
            HSIZE  = vecs[idx].size;
            HTRANS = vecs[idx].trans;
            HBURST = vecs[idx].burst;
        end
    endtask

    // Compares the completing data phase of vector idx.
    task automatic checkOutput(input int idx, input int low);
        checkValue($sformatf("v%0d.resp", idx), 32'(bus_resp), 32'(vecs[idx].exp_resp));
        checkValue($sformatf("v%0d.wait_cycles", idx), 32'(low), 32'(vecs[idx].exp_low));
        if (vecs[idx].chk_data) begin
            checkValue($sformatf("v%0d.hrdata", idx), bus_rdata, vecs[idx].exp_data);
        end
    endtask

    // Pipelined master: next address phase overlaps the current data phase.
    task automatic runVectors(input int first, input int last);
        int   pres     = -1;
        int   data_idx = -1;
        int   nxt      = first;
        int   low      = 0;
        int   cycles   = 0;
        logic prev_acc = 1'b0;
        while (((nxt <= last) || (pres >= 0) || (data_idx >= 0)) && (cycles < 300)) begin
            @(negedge HCLK);
            cycles++;
            if (prev_acc) begin
                data_idx = pres;
                low      = 0;
                HWDATA   = vecs[pres].wdata;
                pres     = -1;
            end
            if ((pres < 0) && (nxt <= last)) begin
                pres = nxt;
                nxt++;
            end
            applyStimulus(pres);
            #1;
            if (data_idx >= 0) begin
                if (HREADY) begin
                    checkOutput(data_idx, low);
                    data_idx = -1;
                end else begin
                    low++;
                end
            end
            prev_acc = (pres >= 0) && HREADY;
        end
        if (cycles >= 300) begin
            checks++;
            failures++;
            $display("[TB] FAIL engine.timeout actual=%0d_cycles required=completion", cycles);
        end
    endtask

    initial begin
        int seg_a_end, seg_b_end, seg_c_end;

        // Segment A: dut0, no wait states.
        addVec(1, 32'h10, HSIZE_WORD, HTRANS_NONSEQ, HBURST_SINGLE, 32'hDEADBEEF, 0, 0, 0, 0);
        addVec(0, 32'h10, HSIZE_WORD, HTRANS_NONSEQ, HBURST_SINGLE, 0, 1, 32'hDEADBEEF, 0, 0);
        addVec(1, 32'h10, HSIZE_WORD, HTRANS_NONSEQ, HBURST_SINGLE, 32'h11223344, 0, 0, 0, 0);
        addVec(1, 32'h13, HSIZE_BYTE, HTRANS_NONSEQ, HBURST_SINGLE, 32'hA5776655, 0, 0, 0, 0);
        addVec(0, 32'h10, HSIZE_WORD, HTRANS_NONSEQ, HBURST_SINGLE, 0, 1, 32'hA5223344, 0, 0);
        addVec(1, 32'h14, HSIZE_WORD, HTRANS_NONSEQ, HBURST_SINGLE, 32'h01020304, 0, 0, 0, 0);
        addVec(1, 32'h16, HSIZE_HALF, HTRANS_NONSEQ, HBURST_SINGLE, 32'hCAFE9999, 0, 0, 0, 0);
        addVec(1, 32'h14, HSIZE_HALF, HTRANS_NONSEQ, HBURST_SINGLE, 32'h12345678, 0, 0, 0, 0);
        addVec(0, 32'h14, HSIZE_WORD, HTRANS_NONSEQ, HBURST_SINGLE, 0, 1, 32'hCAFE5678, 0, 0);
        addVec(0, 32'h02, HSIZE_WORD, HTRANS_NONSEQ, HBURST_SINGLE, 0, 1, 32'h0, 1, 1);
        addVec(0, 32'h10, HSIZE_WORD, HTRANS_NONSEQ, HBURST_SINGLE, 0, 1, 32'hA5223344, 0, 0);
        addVec(1, 32'h11, HSIZE_HALF, HTRANS_NONSEQ, HBURST_SINGLE, 32'hFFFFFFFF, 1, 32'h0, 1, 1);
        addVec(1, 32'h100, HSIZE_WORD, HTRANS_NONSEQ, HBURST_SINGLE, 32'h5555AAAA, 1, 32'h0, 1, 1);
        addVec(1, 32'h18, 3'd3, HTRANS_NONSEQ, HBURST_SINGLE, 32'h77777777, 1, 32'h0, 1, 1);
        addVec(0, 32'h10, HSIZE_WORD, HTRANS_NONSEQ, HBURST_SINGLE, 0, 1, 32'hA5223344, 0, 0);
        addVec(0, 32'h14, HSIZE_WORD, HTRANS_NONSEQ, HBURST_SINGLE, 0, 1, 32'hCAFE5678, 0, 0);
        addVec(1, 32'hFC, HSIZE_WORD, HTRANS_NONSEQ, HBURST_SINGLE, 32'h0BADF00D, 0, 0, 0, 0);
        addVec(0, 32'hFC, HSIZE_WORD, HTRANS_NONSEQ, HBURST_SINGLE, 0, 1, 32'h0BADF00D, 0, 0);
        addVec(1, 32'h40, HSIZE_WORD, HTRANS_NONSEQ, HBURST_SINGLE, 32'h00000000, 0, 0, 0, 0);
        addVec(1, 32'h38, HSIZE_WORD, HTRANS_NONSEQ, HBURST_WRAP4, 32'h0A0A0A0A, 0, 0, 0, 0);
        addVec(1, 32'h3C, HSIZE_WORD, HTRANS_SEQ, HBURST_WRAP4, 32'h0B0B0B0B, 0, 0, 0, 0);
`ifdef AHB_SLV_BURST_CHECK_EN
        addVec(1, 32'h40, HSIZE_WORD, HTRANS_SEQ, HBURST_WRAP4, 32'h0C0C0C0C, 0, 0, 1, 1);
`else
        addVec(1, 32'h40, HSIZE_WORD, HTRANS_SEQ, HBURST_WRAP4, 32'h0C0C0C0C, 0, 0, 0, 0);
`endif
        addVec(0, 32'h38, HSIZE_WORD, HTRANS_NONSEQ, HBURST_SINGLE, 0, 1, 32'h0A0A0A0A, 0, 0);
        addVec(0, 32'h3C, HSIZE_WORD, HTRANS_NONSEQ, HBURST_SINGLE, 0, 1, 32'h0B0B0B0B, 0, 0);
`ifdef AHB_SLV_BURST_CHECK_EN
        addVec(0, 32'h40, HSIZE_WORD, HTRANS_NONSEQ, HBURST_SINGLE, 0, 1, 32'h00000000, 0, 0);
`else
        addVec(0, 32'h40, HSIZE_WORD, HTRANS_NONSEQ, HBURST_SINGLE, 0, 1, 32'h0C0C0C0C, 0, 0);
`endif
        seg_a_end = n_vec - 1;

        // Segment B: dut2, two wait states per OKAY beat.
        addVec(1, 32'h20, HSIZE_WORD, HTRANS_NONSEQ, HBURST_INCR4, 32'h11111111, 0, 0, 0, 2);
        addVec(1, 32'h24, HSIZE_WORD, HTRANS_SEQ, HBURST_INCR4, 32'h22222222, 0, 0, 0, 2);
        addVec(1, 32'h28, HSIZE_WORD, HTRANS_SEQ, HBURST_INCR4, 32'h33333333, 0, 0, 0, 2);
        addVec(1, 32'h2C, HSIZE_WORD, HTRANS_SEQ, HBURST_INCR4, 32'h44444444, 0, 0, 0, 2);
        addVec(0, 32'h20, HSIZE_WORD, HTRANS_NONSEQ, HBURST_INCR4, 0, 1, 32'h11111111, 0, 2);
        addVec(0, 32'h24, HSIZE_WORD, HTRANS_SEQ, HBURST_INCR4, 0, 1, 32'h22222222, 0, 2);
        addVec(0, 32'h28, HSIZE_WORD, HTRANS_SEQ, HBURST_INCR4, 0, 1, 32'h33333333, 0, 2);
        addVec(0, 32'h2C, HSIZE_WORD, HTRANS_SEQ, HBURST_INCR4, 0, 1, 32'h44444444, 0, 2);
        addVec(0, 32'h02, HSIZE_WORD, HTRANS_NONSEQ, HBURST_SINGLE, 0, 1, 32'h0, 1, 1);
        addVec(1, 32'h30, HSIZE_WORD, HTRANS_NONSEQ, HBURST_SINGLE, 32'h600D600D, 0, 0, 0, 2);
        addVec(0, 32'h30, HSIZE_WORD, HTRANS_NONSEQ, HBURST_SINGLE, 0, 1, 32'h600D600D, 0, 2);
        seg_b_end = n_vec - 1;

        // Segment C: dut2 readback after the reset pulse.
        addVec(0, 32'h30, HSIZE_WORD, HTRANS_NONSEQ, HBURST_SINGLE, 0, 1, 32'h600D600D, 0, 2);
        addVec(0, 32'h2C, HSIZE_WORD, HTRANS_NONSEQ, HBURST_SINGLE, 0, 1, 32'h44444444, 0, 2);
        seg_c_end = n_vec - 1;

        HRESETn = 1'b0;
        tgt     = 1'b0;
        hsel0   = 1'b1;
        hsel2   = 1'b0;
        HADDR   = 32'h0;
        HTRANS  = HTRANS_IDLE;
        HWRITE  = 1'b0;
        HSIZE   = HSIZE_WORD;
        HBURST  = HBURST_SINGLE;
        HWDATA  = 32'h0;

        @(negedge HCLK);
        @(negedge HCLK);
        checkValue("reset.dut0.hreadyout", 32'(rdy0), 32'h1);
        checkValue("reset.dut0.hresp", 32'(resp0), 32'h0);
        checkValue("reset.dut0.hrdata", rdata0, 32'h0);
        checkValue("reset.dut2.hreadyout", 32'(rdy2), 32'h1);
        checkValue("reset.dut2.hresp", 32'(resp2), 32'h0);
        checkValue("reset.dut2.hrdata", rdata2, 32'h0);
`ifdef AHB_SLV_BURST_CHECK_EN
        checkValue("reset.dut0.burst_err_cnt", 32'(bec0), 32'h0);
`endif
        HRESETn = 1'b1;

        runVectors(0, seg_a_end);
`ifdef AHB_SLV_BURST_CHECK_EN
        checkValue("wrap4.dut0.burst_err_cnt", 32'(bec0), 32'h1);
`endif

        @(negedge HCLK);
        tgt   = 1'b1;
        hsel0 = 1'b0;
        hsel2 = 1'b1;
        runVectors(seg_a_end + 1, seg_b_end);
`ifdef AHB_SLV_BURST_CHECK_EN
        checkValue("incr4.dut2.burst_err_cnt", 32'(bec2), 32'h0);
`endif

        // Reset pulse while dut2 is holding off a write to 0x30.
        @(negedge HCLK);
        HADDR  = 32'h30;
        HWRITE = 1'b1;
        HSIZE  = HSIZE_WORD;
        HBURST = HBURST_SINGLE;
        HTRANS = HTRANS_NONSEQ;
        #1;
        checkValue("rst.addr_phase_ready", 32'(HREADY), 32'h1);
        @(negedge HCLK);
        HTRANS = HTRANS_IDLE;
        HWDATA = 32'hBAD0BAD0;
        #1;
        checkValue("rst.in_wait_ready", 32'(rdy2), 32'h0);
        #1;
        HRESETn = 1'b0;
        #1;
        checkValue("rst.hreadyout", 32'(rdy2), 32'h1);
        checkValue("rst.hresp", 32'(resp2), 32'h0);
        checkValue("rst.hrdata", rdata2, 32'h0);
`ifdef AHB_SLV_BURST_CHECK_EN
        checkValue("rst.dut0.burst_err_cnt", 32'(bec0), 32'h0);
`endif
        @(negedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;

        runVectors(seg_b_end + 1, seg_c_end);

        @(negedge HCLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
